// File: rtl/mshr_entry_pool_pkg.sv
// Shared MSHR pool types: entry count, index/bitmap/count typedefs and pool FSM states.
// Optional error checking in the pool is enabled by defining MSHR_POOL_ERR_CHK_EN.
package mshr_pkg;

  localparam int MSHR_ENTRY_NUM      = 32;
  localparam int MSHR_ENTRY_ID_WIDTH = $clog2(MSHR_ENTRY_NUM);

  typedef logic [MSHR_ENTRY_ID_WIDTH-1:0] mshr_idx_t;
  typedef logic [MSHR_ENTRY_NUM-1:0]      mshr_oh_t;
  typedef logic [MSHR_ENTRY_ID_WIDTH:0]   mshr_cnt_t;

  typedef enum logic {
    POOL_RUN   = 1'b0,
    POOL_FLUSH = 1'b1
  } pool_state_e;

endpackage

// File: rtl/mshr_entry_pool_if.sv
// Bus between the MSHR entry pool (slave) and its allocator/retire/flush clients (master).
// Error outputs exist only when MSHR_POOL_ERR_CHK_EN is defined.
interface mshr_entry_pool_if
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM      = MSHR_ENTRY_NUM,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM)
);

  logic [ENTRY_NUM-1:0]      v_free_vld;
  logic [ENTRY_NUM-1:0]      v_alloc_oh;
  logic                      rel_vld_0;
  logic                      rel_rdy_0;
  logic [ENTRY_ID_WIDTH-1:0] rel_idx_0;
  logic                      rel_vld_1;
  logic                      rel_rdy_1;
  logic [ENTRY_ID_WIDTH-1:0] rel_idx_1;
  logic                      flush_req;
  logic                      flush_ack;
  logic [ENTRY_ID_WIDTH:0]   free_cnt;
  logic                      free_low;
`ifdef MSHR_POOL_ERR_CHK_EN
  logic                      err_dbl_alloc;
  logic                      err_dbl_free;
`endif

  modport master (
`ifdef MSHR_POOL_ERR_CHK_EN
    input  err_dbl_alloc,
    input  err_dbl_free,
`endif
    input  v_free_vld,
    output v_alloc_oh,
    output rel_vld_0,
    input  rel_rdy_0,
    output rel_idx_0,
    output rel_vld_1,
    input  rel_rdy_1,
    output rel_idx_1,
    output flush_req,
    input  flush_ack,
    input  free_cnt,
    input  free_low
  );

  modport slave (
`ifdef MSHR_POOL_ERR_CHK_EN
    output err_dbl_alloc,
    output err_dbl_free,
`endif
    output v_free_vld,
    input  v_alloc_oh,
    input  rel_vld_0,
    output rel_rdy_0,
    input  rel_idx_0,
    input  rel_vld_1,
    output rel_rdy_1,
    input  rel_idx_1,
    input  flush_req,
    output flush_ack,
    output free_cnt,
    output free_low
  );

endinterface

// File: rtl/mshr_entry_pool_popcount.sv
// Combinational set-bit counter, shared by the MSHR pool and other occupancy counters.
module cmn_popcount #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [CNT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_WIDTH'(bits[i]);
    end
  end

endmodule

// File: rtl/mshr_entry_pool.sv
// MSHR entry busy/free bitmap with one-hot alloc, dual-port release, free count and one-cycle flush.
// Define MSHR_POOL_ERR_CHK_EN to add sticky double-alloc/double-free flags and simulation assertions.
module mshr_entry_pool
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM      = MSHR_ENTRY_NUM,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int LOW_WATER      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mshr_entry_pool_if.slave    bus
);

  localparam int CNT_WIDTH = ENTRY_ID_WIDTH + 1;

  pool_state_e            state_q;
  pool_state_e            state_d;
  logic [ENTRY_NUM-1:0]   busy_q;
  logic [ENTRY_NUM-1:0]   busy_d;
  logic [ENTRY_NUM-1:0]   clr_mask;
  logic [CNT_WIDTH-1:0]   free_cnt_q;
  logic [CNT_WIDTH-1:0]   free_cnt_d;
  logic                   free_low_q;
  logic                   free_low_d;
  logic                   run;
  logic                   hs_0;
  logic                   hs_1;

  assign run  = (state_q == POOL_RUN);
  assign hs_0 = bus.rel_vld_0 & run;
  assign hs_1 = bus.rel_vld_1 & run;

  assign bus.v_free_vld = ~busy_q & {ENTRY_NUM{run}};
  assign bus.rel_rdy_0  = run;
  assign bus.rel_rdy_1  = run;
  assign bus.flush_ack  = (state_q == POOL_FLUSH);
  assign bus.free_cnt   = free_cnt_q;
  assign bus.free_low   = free_low_q;

  // Both ports naming the same index collapse into one bit of the mask.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if ((hs_0 && (bus.rel_idx_0 == ENTRY_ID_WIDTH'(i))) ||
          (hs_1 && (bus.rel_idx_1 == ENTRY_ID_WIDTH'(i)))) begin
        clr_mask[i] = 1'b1;
      end
    end
  end

  // Release clears before alloc sets, so a same-cycle alloc+release leaves the entry busy.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    case (state_q)
      POOL_RUN: begin
        busy_d = (busy_q & ~clr_mask) | bus.v_alloc_oh;
        if (bus.flush_req) begin
          state_d = POOL_FLUSH;
        end
      end
      POOL_FLUSH: begin
        busy_d  = '0;
        state_d = POOL_RUN;
      end
      default: begin
        busy_d  = '0;
        state_d = POOL_RUN;
      end
    endcase
  end

  cmn_popcount #(
    .WIDTH     (ENTRY_NUM),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_free_popcount (
    .bits  (~busy_d),
    .count (free_cnt_d)
  );

  assign free_low_d = (free_cnt_d <= CNT_WIDTH'(LOW_WATER));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= POOL_RUN;
      busy_q     <= '0;
      free_cnt_q <= CNT_WIDTH'(ENTRY_NUM);
      free_low_q <= (ENTRY_NUM <= LOW_WATER);
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      free_low_q <= free_low_d;
    end
  end

`ifdef MSHR_POOL_ERR_CHK_EN
  logic err_dbl_alloc_q;
  logic err_dbl_free_q;

  assign bus.err_dbl_alloc = err_dbl_alloc_q;
  assign bus.err_dbl_free  = err_dbl_free_q;

  // Judged against the post-release bitmap, matching the release-then-alloc ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_dbl_alloc_q <= 1'b0;
      err_dbl_free_q  <= 1'b0;
    end else if (run) begin
      if (|(busy_q & ~clr_mask & bus.v_alloc_oh)) begin
        err_dbl_alloc_q <= 1'b1;
      end
      if (|(clr_mask & ~busy_q & ~bus.v_alloc_oh)) begin
        err_dbl_free_q <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert ($countones(bus.v_alloc_oh) <= 2)
        else $error("mshr_entry_pool: more than two alloc bits in one cycle");
      assert (!bus.rel_vld_0 || (int'(bus.rel_idx_0) < ENTRY_NUM))
        else $error("mshr_entry_pool: rel_idx_0 out of range");
      assert (!bus.rel_vld_1 || (int'(bus.rel_idx_1) < ENTRY_NUM))
        else $error("mshr_entry_pool: rel_idx_1 out of range");
    end
  end
`endif

endmodule

// File: tb/tb_mshr_entry_pool.sv
// Self-checking bench for mshr_entry_pool: directed scenarios plus randomized traffic against a set-based model.
module tb_mshr_entry_pool;
  import mshr_pkg::*;

  localparam int N = MSHR_ENTRY_NUM;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // Reference model: which entries are held, and whether the pool is in its flush cycle.
  bit   m_busy[N];
  bit   m_flush;

  mshr_entry_pool_if bus ();

  mshr_entry_pool dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mshr_oh_t exp_vec();
    mshr_oh_t v;
    v = '0;
    if (!m_flush) begin
      for (int i = 0; i < N; i++) v[i] = !m_busy[i];
    end
    return v;
  endfunction

  function automatic mshr_cnt_t exp_cnt();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
    return mshr_cnt_t'(c);
  endfunction

  task automatic drive_idle();
    bus.v_alloc_oh = '0;
    bus.rel_vld_0  = 1'b0;
    bus.rel_idx_0  = '0;
    bus.rel_vld_1  = 1'b0;
    bus.rel_idx_1  = '0;
    bus.flush_req  = 1'b0;
  endtask

  // Advances one clock and moves the model by the same events; returns at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n || m_flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_flush = 1'b0;
    end else begin
      if (bus.rel_vld_0) m_busy[int'(bus.rel_idx_0)] = 1'b0;
      if (bus.rel_vld_1) m_busy[int'(bus.rel_idx_1)] = 1'b0;
      for (int i = 0; i < N; i++) if (bus.v_alloc_oh[i]) m_busy[i] = 1'b1;
      if (bus.flush_req) m_flush = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    n_checks++;
    if (bus.v_free_vld !== 32'hFFFF_FFFF) begin
      n_errors++; $display("[TB] FAIL reset_vec: got %h want %h", bus.v_free_vld, 32'hFFFF_FFFF);
    end
    n_checks++;
    if (bus.free_cnt !== 6'd32) begin
      n_errors++; $display("[TB] FAIL reset_cnt: got %0d want 32", bus.free_cnt);
    end
    n_checks++;
    if (bus.free_low !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_low: got %b want 0", bus.free_low);
    end
    n_checks++;
    if ({bus.rel_rdy_0, bus.rel_rdy_1, bus.flush_ack} !== 3'b110) begin
      n_errors++; $display("[TB] FAIL reset_rdy_ack: got %b want 110", {bus.rel_rdy_0, bus.rel_rdy_1, bus.flush_ack});
    end
  endtask

  task automatic test_alloc_release();
    do_reset();
    bus.v_alloc_oh = 32'h0000_0003;
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'hFFFF_FFFC || bus.free_cnt !== 6'd30) begin
      n_errors++; $display("[TB] FAIL alloc01: got %h/%0d want FFFFFFFC/30", bus.v_free_vld, bus.free_cnt);
    end
    bus.rel_vld_0 = 1'b1;
    bus.rel_idx_0 = 5'd0;
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'hFFFF_FFFD || bus.free_cnt !== 6'd31) begin
      n_errors++; $display("[TB] FAIL release0: got %h/%0d want FFFFFFFD/31", bus.v_free_vld, bus.free_cnt);
    end
  endtask

  task automatic test_fill_and_dual_release();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.v_alloc_oh = 32'h0000_0003 << (2 * k);
      cycle();
      n_checks++;
      if (bus.free_cnt !== 6'(30 - 2 * k) || bus.free_low !== ((30 - 2 * k) <= 2)) begin
        n_errors++; $display("[TB] FAIL fill_step%0d: got cnt=%0d low=%b want cnt=%0d low=%b",
                             k, bus.free_cnt, bus.free_low, 30 - 2 * k, (30 - 2 * k) <= 2);
      end
    end
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'h0 || bus.free_cnt !== 6'd0 || bus.free_low !== 1'b1) begin
      n_errors++; $display("[TB] FAIL full: got %h/%0d/%b want 0/0/1", bus.v_free_vld, bus.free_cnt, bus.free_low);
    end
    bus.rel_vld_0 = 1'b1; bus.rel_idx_0 = 5'd5;
    bus.rel_vld_1 = 1'b1; bus.rel_idx_1 = 5'd9;
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'h0000_0220 || bus.free_cnt !== 6'd2 || bus.free_low !== 1'b1) begin
      n_errors++; $display("[TB] FAIL dual_release: got %h/%0d/%b want 00000220/2/1", bus.v_free_vld, bus.free_cnt, bus.free_low);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.v_alloc_oh = 32'h0000_0080;
    cycle();
    bus.rel_vld_1 = 1'b1; bus.rel_idx_1 = 5'd7;
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld[7] !== 1'b0 || bus.free_cnt !== 6'd31) begin
      n_errors++; $display("[TB] FAIL alloc_rel_same: got bit7=%b cnt=%0d want 0/31", bus.v_free_vld[7], bus.free_cnt);
    end
    bus.v_alloc_oh = 32'h0000_0008;
    cycle();
    drive_idle();
    bus.rel_vld_0 = 1'b1; bus.rel_idx_0 = 5'd3;
    bus.rel_vld_1 = 1'b1; bus.rel_idx_1 = 5'd3;
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'hFFFF_FF7F || bus.free_cnt !== 6'd31) begin
      n_errors++; $display("[TB] FAIL dup_release: got %h/%0d want FFFFFF7F/31", bus.v_free_vld, bus.free_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.v_alloc_oh = 32'h0000_0003 << (2 * k);
      cycle();
    end
    drive_idle();
    bus.flush_req = 1'b1;
    cycle();
    bus.flush_req = 1'b0;
    n_checks++;
    if ({bus.flush_ack, bus.rel_rdy_0, bus.rel_rdy_1} !== 3'b100 || bus.v_free_vld !== 32'h0 || bus.free_cnt !== 6'd22) begin
      n_errors++; $display("[TB] FAIL flush_cycle: got ack/rdy=%b vec=%h cnt=%0d want 100/0/22",
                           {bus.flush_ack, bus.rel_rdy_0, bus.rel_rdy_1}, bus.v_free_vld, bus.free_cnt);
    end
    bus.rel_vld_0 = 1'b1; bus.rel_idx_0 = 5'd2;
    bus.v_alloc_oh = 32'h0001_0000;
    cycle();
    bus.v_alloc_oh = '0;
    n_checks++;
    if (bus.flush_ack !== 1'b0 || bus.v_free_vld !== 32'hFFFF_FFFF || bus.free_cnt !== 6'd32 || bus.rel_rdy_0 !== 1'b1) begin
      n_errors++; $display("[TB] FAIL after_flush: got ack=%b vec=%h cnt=%0d rdy=%b want 0/FFFFFFFF/32/1",
                           bus.flush_ack, bus.v_free_vld, bus.free_cnt, bus.rel_rdy_0);
    end
    cycle();
    drive_idle();
    n_checks++;
    if (bus.v_free_vld !== 32'hFFFF_FFFF || bus.free_cnt !== 6'd32) begin
      n_errors++; $display("[TB] FAIL late_release: got %h/%0d want FFFFFFFF/32", bus.v_free_vld, bus.free_cnt);
    end
  endtask

  task automatic test_random();
    int idx;
    mshr_oh_t ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      for (int a = 0; a < 2; a++) begin
        idx = int'($urandom_range(N - 1));
        if (!m_busy[idx] || ($urandom_range(7) == 0)) bus.v_alloc_oh[idx] = 1'b1;
      end
      bus.rel_vld_0 = $urandom_range(1);
      bus.rel_idx_0 = mshr_idx_t'($urandom_range(N - 1));
      bus.rel_vld_1 = $urandom_range(1);
      bus.rel_idx_1 = ($urandom_range(3) == 0) ? bus.rel_idx_0 : mshr_idx_t'($urandom_range(N - 1));
      bus.flush_req = ($urandom_range(24) == 0);
      cycle();
      ev = exp_vec();
      n_checks++;
      if (bus.v_free_vld !== ev || bus.free_cnt !== exp_cnt() || bus.free_low !== (exp_cnt() <= 2)) begin
        n_errors++; $display("[TB] FAIL rand_c%0d: got %h/%0d/%b want %h/%0d/%b", c, bus.v_free_vld, bus.free_cnt,
                             bus.free_low, ev, exp_cnt(), exp_cnt() <= 2);
      end
      n_checks++;
      if ({bus.flush_ack, bus.rel_rdy_0, bus.rel_rdy_1} !== {m_flush, !m_flush, !m_flush}) begin
        n_errors++; $display("[TB] FAIL rand_ctl_c%0d: got ack/rdy=%b want %b", c,
                             {bus.flush_ack, bus.rel_rdy_0, bus.rel_rdy_1}, {m_flush, !m_flush, !m_flush});
      end
    end
    drive_idle();
  endtask

`ifdef MSHR_POOL_ERR_CHK_EN
  task automatic test_err_flags();
    do_reset();
    bus.v_alloc_oh = 32'h0000_0010;
    cycle();
    cycle();
    drive_idle();
    cycle();
    n_checks++;
    if (bus.err_dbl_alloc !== 1'b1 || bus.err_dbl_free !== 1'b0) begin
      n_errors++; $display("[TB] FAIL err_alloc: got %b%b want 10", bus.err_dbl_alloc, bus.err_dbl_free);
    end
    bus.rel_vld_0 = 1'b1; bus.rel_idx_0 = 5'd12;
    cycle();
    drive_idle();
    cycle();
    n_checks++;
    if (bus.err_dbl_alloc !== 1'b1 || bus.err_dbl_free !== 1'b1) begin
      n_errors++; $display("[TB] FAIL err_free: got %b%b want 11", bus.err_dbl_alloc, bus.err_dbl_free);
    end
    do_reset();
    n_checks++;
    if (bus.err_dbl_alloc !== 1'b0 || bus.err_dbl_free !== 1'b0) begin
      n_errors++; $display("[TB] FAIL err_reset: got %b%b want 00", bus.err_dbl_alloc, bus.err_dbl_free);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_flush  = 1'b0;
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_alloc_release();
    test_fill_and_dual_release();
    test_same_cycle();
    test_flush();
    test_random();
`ifdef MSHR_POOL_ERR_CHK_EN
    test_err_flags();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mshr_entry_pool.md
Name: mshr_entry_pool

Overview:
- Owns the MSHR entry busy/free state and drives the free-entry vector consumed by the two-port pre-allocator.
- Takes allocation grants back as a per-entry one-hot pulse.
- Accepts up to two entry releases per cycle from MSHR retirement.
- Provides a free count, a low-water flag and a flush sequence.

Parameters:
- ENTRY_NUM, 32, number of MSHR entries.
- ENTRY_ID_WIDTH, $clog2(ENTRY_NUM), entry index width.
- LOW_WATER, 2, free_low asserts when free_cnt <= LOW_WATER.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- v_free_vld  out  ENTRY_NUM  1 = entry free; drives allocator free-pool input
- v_alloc_oh  in  ENTRY_NUM  1 = entry granted this cycle (allocator's v_in_rdy); 0–2 bits set
- rel_vld_0  in  1  release request, port 0
- rel_rdy_0  out  1  release accepted, port 0
- rel_idx_0  in  ENTRY_ID_WIDTH  entry released, port 0
- rel_vld_1 / rel_rdy_1 / rel_idx_1  same, port 1
- flush_req  in  1  request to free all entries (level; held until ack)
- flush_ack  out  1  one-cycle pulse, flush complete
- free_cnt  out  ENTRY_ID_WIDTH+1  number of free entries (registered)
- free_low  out  1  free_cnt <= LOW_WATER

Behaviour:
- Reset (rst_n low at posedge):
  - busy bitmap = 0
  - v_free_vld = all ones
  - free_cnt = ENTRY_NUM
  - free_low = 0 (unless ENTRY_NUM <= LOW_WATER)
  - flush_ack = 0
  - FSM = RUN
  - Reset mid-flush aborts the flush silently.
- State: busy[ENTRY_NUM-1:0] register. v_free_vld = ~busy & {ENTRY_NUM{state==RUN}}. Combinational from the register only; no input-to-output path.
- Allocation:
  - Every set bit of v_alloc_oh sets busy next cycle. Alloc is never back-pressured.
  - Granted entries leave v_free_vld the cycle after the grant.
  - The allocator must not re-grant an entry already in its holding register. This is its responsibility.
- Release:
  - rel_rdy_x = (state==RUN). Handshake = vld & rdy.
  - Accepted index clears busy next cycle. The freed entry appears in v_free_vld 1 cycle after the handshake.
  - Both ports may release in the same cycle.
  - Both ports releasing the same index: a single clear; free_cnt increments by 1.
- Same index allocated and released in the same cycle: release is applied first, then alloc. Entry ends busy.
- free_cnt:
  - Next value = popcount(~busy_next). Computed from the next bitmap so it stays exact under any mix of events.
  - Registered alongside busy.
  - Range 0..ENTRY_NUM; the width carries ENTRY_NUM without overflow.
- free_low: registered compare of free_cnt_next against LOW_WATER.
- FSM RUN/FLUSH:
  - RUN → FLUSH when flush_req=1. That cycle's alloc and release still apply.
  - FLUSH lasts exactly one cycle:
    - v_free_vld = 0 and rel_rdy = 0.
    - Any v_alloc_oh bits are ignored.
    - busy is cleared to 0 at the end of the cycle.
    - flush_ack = 1 in that cycle.
  - FLUSH → RUN unconditionally.
  - flush_req still high in RUN after ack starts another flush. Requesters deassert on ack.
- Full case (all busy): v_free_vld = 0, free_cnt = 0, free_low = 1.
- Empty case (none busy): releases of free entries are legal no-ops; see the optional feature.

Optional Feature:
- Macro MSHR_POOL_ERR_CHK_EN.
- When defined, adds:
  - err_dbl_alloc out 1: alloc bit set on an entry already busy.
  - err_dbl_free out 1: release of an entry that is not busy, excluding an alloc of the same index in the same cycle.
  - Both are sticky; cleared only by reset.
  - Simulation assertions: popcount(v_alloc_oh) <= 2, and rel_idx < ENTRY_NUM.
- When undefined: no error ports and no assertions. Illegal events just update the bitmap per the rules above.

Decomposition:
- Package mshr_pkg holds:
  - MSHR_ENTRY_NUM and MSHR_ENTRY_ID_WIDTH constants.
  - typedef mshr_idx_t.
  - typedef mshr_oh_t (ENTRY_NUM bitmap).
  - enum pool_state_e {POOL_RUN, POOL_FLUSH}.
- One sub-module: cmn_popcount, parameterized width, combinational count of set bits. Shared with other occupancy counters.

Test Plan:
1. Reset then idle: v_free_vld=32'hFFFF_FFFF, free_cnt=32, free_low=0, rel_rdy_0/1=1.
2. Alloc oh bits 0 and 1 in cycle T: cycle T+1 v_free_vld=32'hFFFF_FFFC, free_cnt=30. Release idx 0 on port 0 at T+2: T+3 v_free_vld=32'hFFFF_FFFD, free_cnt=31.
3. Allocate two per cycle for 16 cycles: free_cnt reaches 0, v_free_vld=0. free_low rises when free_cnt_next reaches 2. Dual release idx 5 and 9: next cycle free_cnt=2, bits 5 and 9 set.
4. Entry 7 busy; same cycle alloc bit 7 and release idx 7 on port 1: entry 7 stays busy and free_cnt is unchanged. Dual release of idx 3 on both ports: free_cnt increments by exactly 1.
5. 10 entries busy, assert flush_req: one cycle with flush_ack=1, rel_rdy=0, v_free_vld=0. Next cycle free_cnt=32, all free, ack=0. A rel_vld held through flush completes afterwards as a harmless no-op.
6. With MSHR_POOL_ERR_CHK_EN: alloc bit 4 twice without release → err_dbl_alloc=1 and stays set. Release idx 12 while free → err_dbl_free=1. Both clear only on rst_n=0.
